// File: rtl/vga_axil_regfile.sv
// AXI4-Lite control/status register bank for the VGA core; all registers exported in parallel.
// Define VGA_AXIL_STRB_EN to honour wstrb byte enables (otherwise full-word writes).
module vga_axil_regfile #(
   parameter int unsigned REG_NUM = 8,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic [ADDR_W-1:0]         awaddr,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [DATA_W-1:0]         wdata,
   input  logic [DATA_W/8-1:0]       wstrb,
   input  logic                      wvalid,
   output logic                      wready,
   output logic [1:0]                bresp,
   output logic                      bvalid,
   input  logic                      bready,
   input  logic [ADDR_W-1:0]         araddr,
   input  logic                      arvalid,
   output logic                      arready,
   output logic [DATA_W-1:0]         rdata,
   output logic [1:0]                rresp,
   output logic                      rvalid,
   input  logic                      rready,
   output logic [REG_NUM*DATA_W-1:0] regs_o
);

   localparam logic [1:0] W_IDLE   = 2'd0;
   localparam logic [1:0] W_HALF_A = 2'd1;
   localparam logic [1:0] W_HALF_D = 2'd2;
   localparam logic [1:0] W_RESP   = 2'd3;

   localparam logic R_IDLE = 1'b0;
   localparam logic R_RESP = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [ADDR_W-3:0] REG_LIMIT = (ADDR_W-2)'(REG_NUM);

   logic [1:0]        w_state_q, w_state_d;
   logic              r_state_q;
   logic [ADDR_W-3:0] awidx_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        bresp_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q;
   logic [DATA_W-1:0] regs_q [REG_NUM];

   logic              aw_hs, w_hs, ar_hs, commit;
   logic [ADDR_W-3:0] wr_idx, rd_idx;
   logic              wr_ok, rd_ok;
   logic [DATA_W-1:0] wr_data, wr_mask, rd_word;

   assign awready = (w_state_q == W_IDLE) || (w_state_q == W_HALF_D);
   assign wready  = (w_state_q == W_IDLE) || (w_state_q == W_HALF_A);
   assign bvalid  = (w_state_q == W_RESP);
   assign bresp   = bresp_q;
   assign arready = (r_state_q == R_IDLE);
   assign rvalid  = (r_state_q == R_RESP);
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign ar_hs = arvalid && arready;

   // The completing beat comes from the live bus; the earlier one from the holding register.
   assign wr_idx  = (w_state_q == W_HALF_A) ? awidx_q : awaddr[ADDR_W-1:2];
   assign wr_data = (w_state_q == W_HALF_D) ? wdata_q : wdata;
   assign wr_ok   = (wr_idx < REG_LIMIT);
   assign rd_idx  = araddr[ADDR_W-1:2];
   assign rd_ok   = (rd_idx < REG_LIMIT);

`ifdef VGA_AXIL_STRB_EN
   logic [DATA_W/8-1:0] wstrb_q;
   logic [DATA_W/8-1:0] wr_strb;

   assign wr_strb = (w_state_q == W_HALF_D) ? wstrb_q : wstrb;

   always_comb begin
      wr_mask = '0;
      for (int k = 0; k < DATA_W/8; k++) begin
         wr_mask[k*8 +: 8] = {8{wr_strb[k]}};
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wstrb_q <= '0;
      end else if (w_hs) begin
         wstrb_q <= wstrb;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{awaddr[1:0], araddr[1:0]};
`else
   assign wr_mask = '1;

   logic unused_bits;
   assign unused_bits = ^{awaddr[1:0], araddr[1:0], wstrb};
`endif

   always_comb begin
      w_state_d = w_state_q;
      commit    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               w_state_d = W_RESP;
               commit    = 1'b1;
            end else if (aw_hs) begin
               w_state_d = W_HALF_A;
            end else if (w_hs) begin
               w_state_d = W_HALF_D;
            end
         end
         W_HALF_A: begin
            if (w_hs) begin
               w_state_d = W_RESP;
               commit    = 1'b1;
            end
         end
         W_HALF_D: begin
            if (aw_hs) begin
               w_state_d = W_RESP;
               commit    = 1'b1;
            end
         end
         W_RESP: begin
            if (bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         w_state_q <= W_IDLE;
         awidx_q   <= '0;
         wdata_q   <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         if (aw_hs) awidx_q <= awaddr[ADDR_W-1:2];
         if (w_hs)  wdata_q <= wdata;
         if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (commit && wr_ok && (wr_idx == (ADDR_W-2)'(i))) begin
               regs_q[i] <= (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
            end
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (rd_idx == (ADDR_W-2)'(i)) rd_word = regs_q[i];
      end
   end

   // Capture uses pre-commit register state, so a same-edge write is not visible.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (ar_hs) begin
                  r_state_q <= R_RESP;
                  rdata_q   <= rd_ok ? rd_word : '0;
                  rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
               end
            end
            default: begin
               if (rready) r_state_q <= R_IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < REG_NUM; g++) begin : g_regs_out
      assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
   end

endmodule

// File: doc/vga_axil_regfile.md
# vga_axil_regfile

AXI4-Lite responder holding the VGA core's control/status register bank. It answers the AXI-Lite writes and reads issued by the bus master or bench driver through `vga_axil_if`, and exposes every register in parallel to the VGA timing/pixel logic. A read returns exactly the last value written to that address. Accesses outside the register bank complete with SLVERR and have no side effects.

## Interface
Parameters:
- `REG_NUM`, 8: number of 32-bit registers; must be ≥1 and a power of two.
- `ADDR_W`, 32: AXI address width (`vga_axil_pkg::axil_addr_t`).
- `DATA_W`, 32: AXI data width (`vga_axil_pkg::axil_data_t`); must be 32.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, all logic on rising edge.
- `arst_n` in 1: asynchronous active-low reset.
- `awaddr` in ADDR_W; `awvalid` in 1; `awready` out 1: write-address channel.
- `wdata` in DATA_W; `wstrb` in DATA_W/8; `wvalid` in 1; `wready` out 1: write-data channel.
- `bresp` out 2; `bvalid` out 1; `bready` in 1: write-response channel.
- `araddr` in ADDR_W; `arvalid` in 1; `arready` out 1: read-address channel.
- `rdata` out DATA_W; `rresp` out 2; `rvalid` out 1; `rready` in 1: read-data channel.
- `regs_o` out REG_NUM*DATA_W: register contents, register i at bits [i*DATA_W +: DATA_W].

## Operation
- Decode: index = `addr[ADDR_W-1:2]`. `addr[1:0]` is ignored. Index < REG_NUM gives OKAY (2'b00). Any other index gives SLVERR (2'b10).
- Write FSM states:
  - W_IDLE: `awready`=1 and `wready`=1.
  - W_HALF_A: address held, waiting for data. `awready`=0, `wready`=1.
  - W_HALF_D: data held, waiting for address. `awready`=1, `wready`=0.
  - W_RESP: `bvalid`=1, both readies 0.
- Write transitions:
  - Handshake on AW and W in the same cycle: W_IDLE→W_RESP.
  - AW only: W_IDLE→W_HALF_A. W only: W_IDLE→W_HALF_D.
  - Handshake on the missing channel: W_HALF_A/W_HALF_D→W_RESP.
  - `bvalid`&&`bready`: W_RESP→W_IDLE.
- Write commit: happens on the edge that completes the AW+W pair, the same edge that raises `bvalid`. If the index is out of range, nothing is written and the response is SLVERR.
- Read FSM states:
  - R_IDLE: `arready`=1.
  - R_RESP: `rvalid`=1, `arready`=0.
- Read transitions: `arvalid` moves R_IDLE→R_RESP and latches `rdata`/`rresp` on that edge. `rvalid`&&`rready` returns to R_IDLE.
- Out-of-range read: `rdata`=0, `rresp`=SLVERR.
- Read and write paths are fully independent and may be active at the same time.
- `bresp`, `rdata` and `rresp` stay stable while their valid is high and the response is not yet accepted.

## Timing
- Reset values:
  - All registers 0, so `regs_o`=0.
  - `bvalid`=0, `rvalid`=0, `bresp`=0, `rresp`=0, `rdata`=0.
  - `awready`=`wready`=`arready`=1, because both FSMs reset to IDLE.
- Write latency: AW+W handshaked at edge N gives `bvalid`=1 and the register/`regs_o` updated after edge N. With a zero-wait `bready`, the next AW/W can be accepted at edge N+2.
- Read latency: AR handshaked at edge N gives `rvalid`=1 after edge N. With a zero-wait `rready`, a new AR can be accepted at N+2.
- Same-edge write commit and read capture to the same register: the read returns the old value.
- `bready`/`rready` held low: the response is held indefinitely and no new request on that path is accepted.
- Reset asserted mid-transaction: the FSMs go to IDLE immediately, half-captured AW/W are discarded, and pending responses are dropped.

## Configuration
- `VGA_AXIL_STRB_EN` defined: `wstrb` bit k enables byte k of the write. `wstrb`=0 writes nothing but still returns OKAY for an in-range address.
- `VGA_AXIL_STRB_EN` undefined: `wstrb` is ignored and the full word is written. The port remains present.

## Test plan
- Reset, then write 0x0000_0004 to addr 0x0C with AW and W in the same cycle → `bvalid` one cycle later with `bresp`=00, `regs_o[3]`=4. Reading 0x0C → `rdata`=4, `rresp`=00.
- AW for addr 0x04 at cycle 0, W=0xDEAD_BEEF at cycle 3 → `awready`=0 during cycles 1–3, commit and `bvalid` after cycle 3, readback 0xDEAD_BEEF. Repeat with W first.
- Write/read addr 0x20 with REG_NUM=8 → `bresp`=10 and all registers unchanged; read gives `rdata`=0, `rresp`=10.
- Hold `bready`/`rready` low for 5 cycles → `bvalid`/`rvalid` and data stable, `awready`/`wready`/`arready`=0, then complete normally.
- With `VGA_AXIL_STRB_EN`: reg 1=0x1122_3344, write 0xAABB_CCDD with `wstrb`=0101 → readback 0x11BB_33DD. Without the macro → readback 0xAABB_CCDD.
- Assert `arst_n` while in W_HALF_A and with `rvalid` high → all valids 0 and registers 0. The next full write/read completes correctly.
